// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encoding, FSM states and
// small decode helpers used by both the top level and the divider.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_REM  = 4'd13,
        ALU_REMU = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } alu_seq_state_e;

    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input alu_op_e op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// sign correction applied to the value presented on the final iteration.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic             busy_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             is_rem_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic             done_s;

    // Operand magnitudes and signs captured at start
    always_comb begin
        a_neg_s = is_signed_div(op) && a[WIDTH-1];
        b_neg_s = is_signed_div(op) && b[WIDTH-1];
        abs_a_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
        abs_b_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    end

    // One restoring step; the partial remainder always stays below the divisor,
    // so bit WIDTH of the trial difference is a clean borrow flag
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final value with sign correction: quotient by sign mismatch, remainder by dividend
    always_comb begin
        done_s = busy_r && !abort && (cnt_r == SHW'(WIDTH - 1));
        if (is_rem_r) begin
            result = neg_r_r ? ({WIDTH{1'b0}} - rem_nxt_s) : rem_nxt_s;
        end else begin
            result = neg_q_r ? ({WIDTH{1'b0}} - quo_nxt_s) : quo_nxt_s;
        end
    end

    // Iteration state: counter, partial remainder, quotient shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            cnt_r    <= {SHW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_rem_r <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= {SHW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= abs_a_s;
            dvs_r    <= abs_b_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            is_rem_r <= is_rem_op(op);
        end else if (busy_r) begin
            rem_r  <= rem_nxt_s;
            quo_r  <= quo_nxt_s;
            cnt_r  <= cnt_r + SHW'(1);
            busy_r <= !done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_s;

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle datapath, division fast paths, an
// IDLE/DIV/HOLD control FSM and the registered result stage.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             neg,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

    alu_seq_state_e state_r, state_nxt_s;

    logic [WIDTH-1:0]   q_r;
    logic               zero_r, neg_r, ovf_r, out_valid_r;

    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   sum_s, diff_s;
    logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
    logic               b_zero_s, div_ovf_s, fast_s;
    logic [WIDTH-1:0]   res_s;
    logic               res_ovf_s;
    logic               accept_s, div_start_s;
    logic               div_busy_s, div_done_s;
    logic [WIDTH-1:0]   div_result_s;
    logic               ld_en_s;
    logic [WIDTH-1:0]   ld_val_s;
    logic               ld_ovf_s;

    assign shamt_s  = b[SHW-1:0];
    assign sum_s    = a + b;
    assign diff_s   = a - b;
    assign a_ext_s  = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext_s  = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s   = a_ext_s * b_ext_s;
    assign b_zero_s = (b == {WIDTH{1'b0}});
    assign div_ovf_s = is_signed_div(op) && (a == MIN_VAL) && (b == ONES_VAL);
    assign fast_s   = b_zero_s || div_ovf_s;

    assign in_ready    = !flush && ((state_r == IDLE) || ((state_r == HOLD) && out_ready));
    assign accept_s    = in_valid && in_ready;
    assign div_start_s = accept_s && is_div_op(op) && !fast_s;

    // Single-cycle results, including the division fast paths
    always_comb begin
        res_s     = {WIDTH{1'b0}};
        res_ovf_s = 1'b0;
        case (op)
            ALU_ADD: begin
                res_s     = sum_s;
                res_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res_s     = diff_s;
                res_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  res_s = a & b;
            ALU_OR:   res_s = a | b;
            ALU_XOR:  res_s = a ^ b;
            ALU_SLL:  res_s = a << shamt_s;
            ALU_SRL:  res_s = a >> shamt_s;
            ALU_SRA:  res_s = $unsigned($signed(a) >>> shamt_s);
            ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, a < b};
            ALU_MUL: begin
                res_s     = prod_s[WIDTH-1:0];
                res_ovf_s = (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[2*WIDTH-1]}});
            end
            ALU_DIV, ALU_DIVU: begin
                if (b_zero_s) begin
                    res_s = ONES_VAL;
                end else if (div_ovf_s) begin
                    res_s     = MIN_VAL;
                    res_ovf_s = 1'b1;
                end else begin
                    res_s = {WIDTH{1'b0}};
                end
            end
            ALU_REM, ALU_REMU: begin
                if (b_zero_s) begin
                    res_s = a;
                end else if (div_ovf_s) begin
                    res_s     = {WIDTH{1'b0}};
                    res_ovf_s = 1'b1;
                end else begin
                    res_s = {WIDTH{1'b0}};
                end
            end
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (flush),
        .start  (div_start_s),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (div_busy_s),
        .done   (div_done_s),
        .result (div_result_s)
    );

    // Next-state logic; flush overrides accept and completion
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = div_start_s ? DIV : HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_nxt_s = div_start_s ? DIV : HOLD;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Select what, if anything, lands in the result registers this edge
    always_comb begin
        ld_en_s  = 1'b0;
        ld_val_s = res_s;
        ld_ovf_s = res_ovf_s;
        if (accept_s && !div_start_s) begin
            ld_en_s = 1'b1;
        end else if (div_done_s) begin
            ld_en_s  = 1'b1;
            ld_val_s = div_result_s;
            ld_ovf_s = 1'b0;
        end else begin
            ld_en_s = 1'b0;
        end
    end

    // Result registers; zero/neg are captured from the same value as q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (ld_en_s) begin
            q_r         <= ld_val_s;
            zero_r      <= (ld_val_s == {WIDTH{1'b0}});
            neg_r       <= ld_val_s[WIDTH-1];
            ovf_r       <= ld_ovf_s;
            out_valid_r <= 1'b1;
        end else if (accept_s || out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign q         = q_r;
    assign zero      = zero_r;
    assign neg       = neg_r;
    assign overflow  = ovf_r;
    assign out_valid = out_valid_r;
    assign busy      = div_busy_s;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    alu_op_e      op = ALU_ADD;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] q;
    logic         zero, neg, overflow, busy;

    int checks = 0;
    int errors = 0;
    int stall_mode = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         ovf;
    } exp_t;
    exp_t sbq[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .q(q), .zero(zero), .neg(neg),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx, sy, r, maxs, mins;
        maxs = 64'sd2147483647;
        mins = -maxs - 64'sd1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.q = '0;
        e.ovf = 1'b0;
        case (o)
            ALU_ADD:  begin r = sx + sy; e.q = r[W-1:0]; e.ovf = (r > maxs) || (r < mins); end
            ALU_SUB:  begin r = sx - sy; e.q = r[W-1:0]; e.ovf = (r > maxs) || (r < mins); end
            ALU_AND:  e.q = x & y;
            ALU_OR:   e.q = x | y;
            ALU_XOR:  e.q = x ^ y;
            ALU_SLL:  e.q = x << y[4:0];
            ALU_SRL:  e.q = x >> y[4:0];
            ALU_SRA:  e.q = $unsigned($signed(x) >>> y[4:0]);
            ALU_SLT:  e.q = (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLTU: e.q = (x < y) ? 32'd1 : 32'd0;
            ALU_MUL:  begin r = sx * sy; e.q = r[W-1:0]; e.ovf = (r > maxs) || (r < mins); end
            ALU_DIV: begin
                if (y == 0) e.q = '1;
                else if (sx == mins && sy == -64'sd1) begin e.q = x; e.ovf = 1'b1; end
                else begin r = sx / sy; e.q = r[W-1:0]; end
            end
            ALU_DIVU: e.q = (y == 0) ? '1 : x / y;
            ALU_REM: begin
                if (y == 0) e.q = x;
                else if (sx == mins && sy == -64'sd1) begin e.q = '0; e.ovf = 1'b1; end
                else begin r = sx % sy; e.q = r[W-1:0]; end
            end
            ALU_REMU: e.q = (y == 0) ? x : x % y;
            default:  e.q = '0;
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'h7fffffff;
            5: return 32'($urandom_range(0, 40));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Present one operation and wait (bounded) for it to be accepted
    task automatic issue(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            #4;
            acc = in_ready;
            @(posedge clk);
            if (acc) sbq.push_back(model(o, x, y));
            else begin
                waited++;
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL issue_timeout: op %0d not accepted after %0d cycles, expected acceptance", o, waited);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
        end
    endtask

    // Monitor: drives out_ready and checks each consumed result against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (stall_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got q=%h, expected no result", q);
                end else begin
                    e = sbq.pop_front();
                    if ({q, overflow, zero, neg} !== {e.q, e.ovf, e.q == 0, e.q[W-1]}) begin
                        errors++;
                        $display("FAIL result: got q=%h ovf=%b z=%b n=%b expected q=%h ovf=%b z=%b n=%b",
                                 q, overflow, zero, neg, e.q, e.ovf, e.q == 0, e.q[W-1]);
                    end
                end
            end
        end
    end

    initial begin
        int w, n, bc;
        logic [W-1:0] sq;
        logic [3:0]   sf;

        repeat (2) @(negedge clk);
        chk("reset_state", {q, zero, neg, overflow, out_valid, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_mode = 0;

        issue(ALU_ADD, 32'h7fffffff, 32'h1, w);
        issue(ALU_SUB, 32'h0, 32'h0, w);

        issue(ALU_DIV, 32'hfffffff9, 32'h2, w);
        n = 0; bc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (busy) bc++;
        end
        chk("div_latency", 64'(n), 64'd33);
        chk("div_busy_cycles", 64'(bc), 64'd32);

        issue(ALU_REM, 32'hfffffff9, 32'h2, w);
        issue(ALU_DIVU, 32'd100, 32'd7, w);
        issue(ALU_REMU, 32'd100, 32'd7, w);

        issue(ALU_DIVU, 32'd5, 32'd0, w);
        @(negedge clk);
        chk("divu_by_zero_fast", {62'd0, out_valid, busy}, 64'd2);
        issue(ALU_DIV, 32'h80000000, 32'hffffffff, w);
        @(negedge clk);
        chk("div_ovf_fast", {62'd0, out_valid, busy}, 64'd2);

        // Backpressure: result must stay bit-stable while out_ready is low
        drain();
        stall_mode = 2;
        issue(ALU_ADD, 32'h80000000, 32'h80000000, w);
        @(negedge clk);
        #2;
        sq = q;
        sf = {zero, neg, overflow, out_valid};
        chk("hold_first_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("hold_stable", {q, zero, neg, overflow, out_valid, in_ready}, {sq, sf, 1'b0});
        end
        stall_mode = 0;
        issue(ALU_XOR, 32'hdeadbeef, 32'h12345678, w);
        chk("release_same_cycle", 64'(w), 64'd0);

        // Flush in the middle of a division
        drain();
        issue(ALU_DIVU, 32'hdeadbeef, 32'h1234, w);
        repeat (10) @(negedge clk);
        chk("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_abort", {62'd0, busy, out_valid}, 64'd0);
        void'(sbq.pop_back());
        repeat (40) @(negedge clk);
        issue(ALU_ADD, 32'd100, 32'd23, w);

        // Asynchronous reset between edges mid-division
        drain();
        issue(ALU_DIVU, 32'($urandom()), 32'($urandom_range(1, 1000)), w);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {q, zero, neg, overflow, out_valid, busy}, 64'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(ALU_SLL, 32'h1, 32'h25, w);
        drain();

        // Randomized traffic with random backpressure
        stall_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(alu_op_e'(4'($urandom_range(0, 15))), rnd_opnd(), rnd_opnd(), w);
        end
        stall_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU. Adds WIDTH generalisation, real signed overflow, a registered result stage, MUL, and an iterative radix-2 DIV/DIVU/REM/REMU unit.
- Sits in the EX stage. The pipeline control uses in_ready/out_valid to stall the pipeline while a division runs.

Parameters:
- WIDTH, 32, operand and result width; must be at least 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of any in-flight or held result.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  alu_op_e  operation, from alu_pkg.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- q  output  WIDTH  result.
- zero  output  1  q is all zeros.
- neg  output  1  q[WIDTH-1].
- overflow  output  1  signed overflow or division overflow.
- busy  output  1  division iteration in progress.

Behaviour:
- Reset: asynchronous active-low, as already decided. All outputs and state clear: q=0, zero=0, neg=0, overflow=0, out_valid=0, busy=0, FSM in IDLE. Asserting reset mid-division abandons the division with no residue.
- FSM states:
  - IDLE: waiting for an operation.
  - DIV: iterating.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready), and is forced to 0 while flush=1.
- Accept: in_valid && in_ready at a rising edge.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL):
  - Result is registered at the accept edge; out_valid=1 on the next cycle (latency 1). State goes to HOLD.
  - Back-to-back accepts give one result per cycle when out_ready is held high.
- Shifts: the shift amount is b[SHW-1:0]; upper bits of b are ignored.
- MUL: q = low WIDTH bits of a*b. overflow=1 iff the signed full product does not fit in WIDTH bits.
- ADD/SUB: overflow is two's-complement signed overflow, e.g. ADD: a[W-1]==b[W-1] && q[W-1]!=a[W-1].
- overflow=0 for all other non-division ops.
- Division, normal case: accept moves to DIV with busy=1. Operands are latched as absolute values with sign flags. The unit runs exactly WIDTH iterations of restoring division, one quotient bit per cycle. The result is registered on the final iteration edge, so out_valid is first seen WIDTH+1 cycles after accept; then state is HOLD with busy=0.
- Division fast path, latency 1, no DIV state:
  - b==0: DIV/DIVU q = all ones; REM/REMU q = a; overflow=0.
  - Signed a==MIN and b==-1: DIV q = MIN, overflow=1; REM q = 0, overflow=1.
- Division signs: quotient is negative iff the operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- zero and neg are always derived from the registered q, never from intermediate values.
- Backpressure: in HOLD with out_ready=0, q and all flags stay bit-stable and in_ready=0.
- flush:
  - Next state is IDLE and out_valid=0.
  - Any division is aborted and busy=0.
  - q keeps its old value, which is don't-care.
  - flush takes priority over a simultaneous accept or completion.
- Unknown op: q=0, flags derived from q (zero=1, neg=0), overflow=0, latency 1.

Decomposition:
- alu_pkg gains:
  - enum values ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU;
  - the FSM state typedef alu_seq_state_e (IDLE, DIV, HOLD);
  - helper function is_div_op(alu_op_e).
- One sub-module, alu_divider, owns the iteration counter, the partial remainder and quotient shift registers, and the sign correction. It has a start/done interface and an abort input driven by flush.
- The top level holds the combinational single-cycle datapath, the FSM and the output registers.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF b=1, out_ready=1 -> one cycle later q=0x80000000, overflow=1, neg=1, zero=0. SUB a=0 b=0 -> q=0, zero=1, overflow=0.
- DIV a=-7 b=2 -> busy for 32 cycles, out_valid on cycle 33: q=-3 (0xFFFFFFFD). REM a=-7 b=2 -> q=-1. DIVU 100/7 -> q=14. REMU 100/7 -> q=2.
- DIVU a=5 b=0 -> latency 1, q=0xFFFFFFFF. DIV a=0x80000000 b=-1 -> q=0x80000000, overflow=1, busy never asserted.
- Hold out_ready=0 for 5 cycles after an ADD result -> q and flags stable, in_ready=0. Release -> next queued op accepted the same cycle.
- Start DIVU, pulse flush at iteration 10 -> busy=0 and out_valid=0 next cycle. A new ADD accepted afterwards returns the correct result.
- Deassert rst_n mid-division (asynchronously, between edges) -> outputs zero immediately. After release, SLL a=1 b=0x25 -> q=0x20 (only b[4:0]=5 used).
